game_sequencer: RTL and testbench
=================================

// Module: game_sequencer
// PURPOSE
//  Top-level play-state controller for the snake game. Sequences the score datapath and display:
//  - sits between the posedge-detected pushbuttons / collision detector and score_tracker + ssdec
//  - generates snake move ticks whose rate rises with score
//  - issues one-cycle score increment / fail pulses
//  - selects current-vs-high score display and blink during end-of-game hold.
// PARAMETERS
//  TICK_DIV_INIT  50   clk cycles per move tick at game start (0.5 s at hz100)
//  TICK_DIV_MIN   10   floor for cycles per move tick
//  DIV_DEC        5    tick divider decrement per speed-up
//  SPEEDUP_STEP   5    points between speed-ups
//  MAX_SCORE      50   score that ends the game as a win
//  OVER_HOLD      300  cycles spent in GAME_OVER/WIN before auto-return to IDLE
// PORTS
//  clk         in   1  system clock (hz100)
//  rst         in   1  synchronous reset, active-high
//  start_btn   in   1  one-cycle pulse (edge-detected pb)
//  pause_btn   in   1  one-cycle pulse, toggles pause
//  good_coll   in   1  one-cycle pulse: snake ate food
//  bad_coll    in   1  one-cycle pulse: snake hit wall/self
//  cur_score   in   7  current score from score_tracker (0..MAX_SCORE)
//  move_tick   out  1  one-cycle pulse: advance snake one cell
//  score_inc   out  1  one-cycle pulse to score_tracker goodColl
//  score_fail  out  1  one-cycle pulse to score_tracker badColl
//  game_clr    out  1  one-cycle pulse: clear snake/board for new game
//  disp_high   out  1  1 = display high score, 0 = current score
//  blink_en    out  1  display blink enable (end-of-game hold only)
//  state       out  3  game_state_t encoding, for debug / LEDs
// BEHAVIOUR
//  - All outputs registered, asserted one cycle after the causing input edge.
//  - Reset: state=IDLE, tick_cnt=0, tick_div=TICK_DIV_INIT, step_cnt=0, hold_cnt=0;
//    all pulse outputs 0, disp_high=1, blink_en=0. rst mid-game aborts to IDLE on next edge.
//  - IDLE: disp_high=1; collisions and pause ignored.
//    start_btn -> RUN; game_clr=1 for one cycle; tick_div=INIT; tick_cnt=0; step_cnt=0.
//  - RUN: disp_high=0. tick_cnt increments each cycle;
//    at tick_cnt==tick_div-1: move_tick=1, tick_cnt=0.
//  - RUN, good_coll: score_inc=1 and step_cnt++.
//    When step_cnt wraps at SPEEDUP_STEP: tick_div = max(tick_div-DIV_DEC, TICK_DIV_MIN),
//    applied from the next tick period (tick_cnt not reset).
//  - RUN, good_coll with cur_score==MAX_SCORE-1: score_inc=1, -> WIN.
//  - RUN, bad_coll: score_fail=1, -> GAME_OVER.
//  - Priority within a RUN cycle: bad_coll > good_coll.
//    good_coll+bad_coll in the same cycle: score_fail only, no score_inc.
//  - RUN, pause_btn: -> PAUSE. A simultaneous good_coll is still scored;
//    a simultaneous bad_coll wins (-> GAME_OVER, pause dropped).
//  - PAUSE: tick_cnt frozen, no move_tick, collisions ignored, start_btn ignored.
//    pause_btn -> RUN, tick_cnt resumes from frozen value.
//  - GAME_OVER / WIN: disp_high=1, blink_en=1; hold_cnt counts 0..OVER_HOLD-1;
//    all buttons ignored. At OVER_HOLD-1: -> IDLE, blink_en=0, hold_cnt=0.
//  - tick_div width: $clog2(TICK_DIV_INIT+1). DIV_DEC subtraction saturates at TICK_DIV_MIN,
//    never underflows.
//  - move_tick never asserts outside RUN; at most one pulse of each pulse output per cycle.
// STRUCTURE
//  - snake_pkg: typedef enum logic[2:0] game_state_t {IDLE, RUN, PAUSE, GAME_OVER, WIN};
//    shared default constants (TICK_DIV_INIT, MAX_SCORE).
//  - Sub-module move_tick_gen:
//    - inputs: clk, rst, en, clr, div
//    - outputs: tick
//    - owns tick_cnt; freeze when en=0.
//  - FSM, speed-up logic and hold counter stay in game_sequencer.
// TESTING
//  - rst, start_btn@c5 -> game_clr=1 @c6 only; state=RUN; first move_tick 50 cycles after entry,
//    then every 50.
//  - 5 good_coll pulses in RUN -> 5 score_inc pulses; tick period becomes 45;
//    after 40 more points period clamps at 10.
//  - good_coll+bad_coll same cycle -> score_fail=1, score_inc=0; GAME_OVER, blink_en=1;
//    IDLE exactly 300 cycles later.
//  - pause_btn at tick_cnt=20 -> no move_tick for 100 cycles; pause_btn again ->
//    next move_tick 30 cycles later.
//  - cur_score=49, good_coll -> score_inc=1, state=WIN, disp_high=1; start_btn during hold ignored.
//  - rst asserted mid-RUN -> next edge: IDLE, outputs at reset values, tick_div=50.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types and default constants for the snake game play-state logic.
package snake_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    PAUSE     = 3'd2,
    GAME_OVER = 3'd3,
    WIN       = 3'd4
  } game_state_t;

  localparam int unsigned DEF_TICK_DIV_INIT = 50;
  localparam int unsigned DEF_MAX_SCORE     = 50;

endpackage

// File: rtl/move_tick_gen.sv
// Move tick generator: emits a registered one-cycle tick every `period` enabled cycles.
module move_tick_gen
  import snake_pkg::*;
#(
  parameter int unsigned DW       = 6,
  parameter int unsigned DIV_INIT = DEF_TICK_DIV_INIT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic [DW-1:0] div,
  output logic          tick
);

  localparam logic [DW-1:0] ONE = DW'(1);

  logic [DW-1:0] tick_cnt;
  logic [DW-1:0] period;

  // The period is latched only at a wrap (or clear), so a new divider takes
  // effect from the next tick period without disturbing the running count.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      period   <= DW'(DIV_INIT);
      tick     <= 1'b0;
    end else if (clr) begin
      tick_cnt <= '0;
      period   <= div;
      tick     <= 1'b0;
    end else if (en) begin
      if (tick_cnt == period - ONE) begin
        tick_cnt <= '0;
        period   <= div;
        tick     <= 1'b1;
      end else begin
        tick_cnt <= tick_cnt + ONE;
        tick     <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Play-state controller for the snake game: move tick pacing, score pulses,
// speed-up on score, and display/blink selection for the end-of-game hold.
module game_sequencer
  import snake_pkg::*;
#(
  parameter int unsigned TICK_DIV_INIT = DEF_TICK_DIV_INIT,
  parameter int unsigned TICK_DIV_MIN  = 10,
  parameter int unsigned DIV_DEC       = 5,
  parameter int unsigned SPEEDUP_STEP  = 5,
  parameter int unsigned MAX_SCORE     = DEF_MAX_SCORE,
  parameter int unsigned OVER_HOLD     = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       good_coll,
  input  logic       bad_coll,
  input  logic [6:0] cur_score,
  output logic       move_tick,
  output logic       score_inc,
  output logic       score_fail,
  output logic       game_clr,
  output logic       disp_high,
  output logic       blink_en,
  output logic [2:0] state
);

  localparam int unsigned DW = $clog2(TICK_DIV_INIT + 1);
  localparam int unsigned SW = $clog2(SPEEDUP_STEP + 1);
  localparam int unsigned HW = $clog2(OVER_HOLD + 1);

  localparam logic [DW-1:0] DIV_FLOOR = DW'(TICK_DIV_MIN + DIV_DEC);

  game_state_t   st_q, st_d;
  logic [DW-1:0] div_q, div_d;
  logic [SW-1:0] step_q, step_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          inc_d, fail_d, clr_d, tick_en;

  always_comb begin
    st_d   = st_q;
    div_d  = div_q;
    step_d = step_q;
    hold_d = '0;
    inc_d  = 1'b0;
    fail_d = 1'b0;
    clr_d  = 1'b0;
    case (st_q)
      IDLE: begin
        if (start_btn) begin
          st_d   = RUN;
          clr_d  = 1'b1;
          div_d  = DW'(TICK_DIV_INIT);
          step_d = '0;
        end
      end
      RUN: begin
        if (bad_coll) begin
          fail_d = 1'b1;
          st_d   = GAME_OVER;
        end else begin
          if (good_coll) begin
            inc_d = 1'b1;
            if (step_q == SW'(SPEEDUP_STEP - 1)) begin
              step_d = '0;
              div_d  = (div_q >= DIV_FLOOR) ? div_q - DW'(DIV_DEC) : DW'(TICK_DIV_MIN);
            end else begin
              step_d = step_q + SW'(1);
            end
            if (cur_score == 7'(MAX_SCORE - 1)) st_d = WIN;
          end
          if (pause_btn && st_d == RUN) st_d = PAUSE;
        end
      end
      PAUSE: begin
        if (pause_btn) st_d = RUN;
      end
      GAME_OVER, WIN: begin
        if (hold_q == HW'(OVER_HOLD - 1)) st_d = IDLE;
        else                              hold_d = hold_q + HW'(1);
      end
      default: st_d = IDLE;
    endcase
    // Count only on cycles that both start and stay in RUN, so ticks never
    // coincide with leaving RUN and a pause freezes the count it was given.
    tick_en = (st_q == RUN) && (st_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= IDLE;
      div_q      <= DW'(TICK_DIV_INIT);
      step_q     <= '0;
      hold_q     <= '0;
      score_inc  <= 1'b0;
      score_fail <= 1'b0;
      game_clr   <= 1'b0;
      disp_high  <= 1'b1;
      blink_en   <= 1'b0;
    end else begin
      st_q       <= st_d;
      div_q      <= div_d;
      step_q     <= step_d;
      hold_q     <= hold_d;
      score_inc  <= inc_d;
      score_fail <= fail_d;
      game_clr   <= clr_d;
      disp_high  <= (st_d == IDLE) || (st_d == GAME_OVER) || (st_d == WIN);
      blink_en   <= (st_d == GAME_OVER) || (st_d == WIN);
    end
  end

  assign state = st_q;

  move_tick_gen #(
    .DW       (DW),
    .DIV_INIT (TICK_DIV_INIT)
  ) u_move_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (tick_en),
    .clr  (clr_d),
    .div  (div_d),
    .tick (move_tick)
  );

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: vector table for per-cycle decisions plus
// hand-written sequences for tick pacing, speed-up, pause, hold and reset.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_btn, pause_btn, good_coll, bad_coll;
  logic [6:0] cur_score;
  logic       move_tick, score_inc, score_fail, game_clr, disp_high, blink_en;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_OVER = 3, S_WIN = 4;

  game_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start_btn  (start_btn),
    .pause_btn  (pause_btn),
    .good_coll  (good_coll),
    .bad_coll   (bad_coll),
    .cur_score  (cur_score),
    .move_tick  (move_tick),
    .score_inc  (score_inc),
    .score_fail (score_fail),
    .game_clr   (game_clr),
    .disp_high  (disp_high),
    .blink_en   (blink_en),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit start, pause, good, bad;
    bit inc, fail, clr, dh, bl;
    int st;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit later and pulse inputs dropped.
  task automatic cyc();
    @(posedge clk);
    #1;
    start_btn = 1'b0;
    pause_btn = 1'b0;
    good_coll = 1'b0;
    bad_coll  = 1'b0;
  endtask

  task automatic wait_tick(input int max, output int n);
    bit found = 0;
    n = -1;
    for (int i = 1; i <= max && !found; i++) begin
      cyc();
      if (move_tick) begin
        n = i;
        found = 1;
      end
    end
  endtask

  task automatic wait_idle(input int max, output int n);
    bit found = 0;
    n = -1;
    for (int i = 1; i <= max && !found; i++) begin
      cyc();
      if (state == 3'(S_IDLE)) begin
        n = i;
        found = 1;
      end
    end
  endtask

  initial begin
    int n, cnt, bad_st;

    vecs[0]  = '{0,0,0,0, 0,0,0,1,0, S_IDLE};
    vecs[1]  = '{0,0,1,0, 0,0,0,1,0, S_IDLE};
    vecs[2]  = '{0,1,0,1, 0,0,0,1,0, S_IDLE};
    vecs[3]  = '{1,0,0,0, 0,0,1,0,0, S_RUN};
    vecs[4]  = '{0,0,0,0, 0,0,0,0,0, S_RUN};
    vecs[5]  = '{0,0,1,0, 1,0,0,0,0, S_RUN};
    vecs[6]  = '{0,1,1,0, 1,0,0,0,0, S_PAUSE};
    vecs[7]  = '{0,0,1,0, 0,0,0,0,0, S_PAUSE};
    vecs[8]  = '{0,0,0,1, 0,0,0,0,0, S_PAUSE};
    vecs[9]  = '{1,0,0,0, 0,0,0,0,0, S_PAUSE};
    vecs[10] = '{0,1,0,0, 0,0,0,0,0, S_RUN};
    vecs[11] = '{0,0,1,1, 0,1,0,1,1, S_OVER};
    vecs[12] = '{1,1,0,0, 0,0,0,1,1, S_OVER};

    rst = 1'b1; start_btn = 0; pause_btn = 0; good_coll = 0; bad_coll = 0; cur_score = '0;
    cyc(); cyc();
    rst = 1'b0;
    check("rst_state", state, S_IDLE);
    check("rst_disp_high", disp_high, 1);
    check("rst_blink", blink_en, 0);
    check("rst_pulses", {move_tick, score_inc, score_fail, game_clr}, 0);

    foreach (vecs[i]) begin
      start_btn = vecs[i].start;
      pause_btn = vecs[i].pause;
      good_coll = vecs[i].good;
      bad_coll  = vecs[i].bad;
      cyc();
      check($sformatf("v%0d_state", i), state, vecs[i].st);
      check($sformatf("v%0d_inc", i), score_inc, vecs[i].inc);
      check($sformatf("v%0d_fail", i), score_fail, vecs[i].fail);
      check($sformatf("v%0d_clr", i), game_clr, vecs[i].clr);
      check($sformatf("v%0d_disp_high", i), disp_high, vecs[i].dh);
      check($sformatf("v%0d_blink", i), blink_en, vecs[i].bl);
      check($sformatf("v%0d_tick", i), move_tick, 0);
    end

    // GAME_OVER entered on vector 11; one more edge elapsed in vector 12.
    wait_idle(400, n);
    check("over_hold_len", (n < 0) ? -1 : n + 1, 300);
    check("over_exit_blink", blink_en, 0);
    check("over_exit_disp_high", disp_high, 1);

    repeat (3) cyc();
    start_btn = 1'b1;
    cyc();
    check("start_clr", game_clr, 1);
    check("start_state", state, S_RUN);
    wait_tick(200, n);
    check("first_tick_gap", n, 50);
    check("clr_single", game_clr, 0);
    wait_tick(200, n);
    check("second_tick_gap", n, 50);

    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      good_coll = 1'b1;
      cyc();
      cnt += int'(score_inc);
    end
    check("five_incs", cnt, 5);
    wait_tick(200, n);
    check("old_period_kept", n, 45);
    wait_tick(200, n);
    check("period_45", n, 45);

    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      good_coll = 1'b1;
      cyc();
      cnt += int'(score_inc);
    end
    check("forty_incs", cnt, 40);
    wait_tick(200, n);
    wait_tick(200, n);
    check("period_min_a", n, 10);
    wait_tick(200, n);
    check("period_min_b", n, 10);

    rst = 1'b1; cyc(); rst = 1'b0;
    start_btn = 1'b1; cyc();
    wait_tick(200, n);
    check("pause_setup_tick", n, 50);
    repeat (20) cyc();
    pause_btn = 1'b1;
    cyc();
    check("pause_state", state, S_PAUSE);
    cnt = 0; bad_st = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      cnt += int'(move_tick);
      if (state != 3'(S_PAUSE)) bad_st++;
    end
    check("pause_no_tick", cnt, 0);
    check("pause_held", bad_st, 0);
    pause_btn = 1'b1;
    cyc();
    check("resume_state", state, S_RUN);
    wait_tick(200, n);
    check("resume_tick_gap", n, 30);

    cur_score = 7'd49;
    good_coll = 1'b1;
    cyc();
    cur_score = '0;
    check("win_inc", score_inc, 1);
    check("win_state", state, S_WIN);
    check("win_disp_high", disp_high, 1);
    check("win_blink", blink_en, 1);
    start_btn = 1'b1;
    cyc();
    check("win_start_ignored", state, S_WIN);
    check("win_no_clr", game_clr, 0);
    wait_idle(400, n);
    check("win_hold_len", (n < 0) ? -1 : n + 1, 300);

    start_btn = 1'b1; cyc();
    for (int i = 0; i < 5; i++) begin
      good_coll = 1'b1;
      cyc();
    end
    repeat (10) cyc();
    rst = 1'b1; good_coll = 1'b1;
    cyc();
    rst = 1'b0;
    check("midrst_state", state, S_IDLE);
    check("midrst_disp_high", disp_high, 1);
    check("midrst_blink", blink_en, 0);
    check("midrst_pulses", {move_tick, score_inc, score_fail, game_clr}, 0);
    start_btn = 1'b1; cyc();
    wait_tick(200, n);
    check("midrst_div_init", n, 50);

    bad_coll = 1'b1;
    cyc();
    check("bad_fail", score_fail, 1);
    check("bad_state", state, S_OVER);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
